// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // RUN: pipe advances normally. MEMWAIT: a data-memory access in M is
  // still outstanding, so every pipeline register holds.
  typedef enum logic [0:0] {
    HZ_RUN     = 1'b0,
    HZ_MEMWAIT = 1'b1
  } hz_state_t;

  // Register $0 is hard-wired to zero. It never produces a hazard.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding selector for a single Decode source operand.
// The youngest producer wins: E beats M, and M beats W.
// A load sitting in E is not a valid source because its data does not exist yet.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0]  src,
  input  logic        use_src,
  input  logic [4:0]  write_reg_e,
  input  logic [4:0]  write_reg_m,
  input  logic [4:0]  write_reg_w,
  input  logic        reg_write_e,
  input  logic        reg_write_m,
  input  logic        reg_write_w,
  input  logic        mem_to_reg_e,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] result_m,
  input  logic [31:0] result_w,
  output logic        enabled,
  output logic [31:0] value
);

  logic reads_reg;
  logic match_e;
  logic match_m;
  logic match_w;

  // Detect a producer in each stage, then apply E > M > W priority.
  always_comb begin
    reads_reg = use_src && (src != REG_ZERO);
    match_e   = reads_reg && reg_write_e && !mem_to_reg_e && (write_reg_e == src);
    match_m   = reads_reg && reg_write_m && (write_reg_m == src);
    match_w   = reads_reg && reg_write_w && (write_reg_w == src);
    enabled   = 1'b0;
    value     = 32'd0;
    if (match_e) begin
      enabled = 1'b1;
      value   = alu_out_e;
    end else if (match_m) begin
      enabled = 1'b1;
      value   = result_m;
    end else if (match_w) begin
      enabled = 1'b1;
      value   = result_w;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS32 pipeline. It does four things:
// - forwards RAW operands into the D->E register,
// - inserts load-use bubbles,
// - squashes wrong-path instructions when E redirects the PC,
// - freezes the pipe while data memory waits.
// Memory handshake: dmem_req_m says M has an access in flight. The access
// completes in the cycle where dmem_ready_m is 1. Every cycle in which the
// access is not yet complete is a full-pipe stall.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic [4:0]       write_reg_e,
  input  logic [4:0]       write_reg_m,
  input  logic [4:0]       write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic [31:0]      alu_out_e,
  input  logic [31:0]      result_m,
  input  logic [31:0]      result_w,
  input  logic             branch_taken_e,
  input  logic             dmem_req_m,
  input  logic             dmem_ready_m,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             forward_src_a_enabled,
  output logic [31:0]      forward_src_a,
  output logic             forward_src_b_enabled,
  output logic [31:0]      forward_src_b,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output hz_state_t        state
);

  localparam int unsigned         WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              fwd_a_en;
  logic              fwd_b_en;
  logic [31:0]       fwd_a_val;
  logic [31:0]       fwd_b_val;
  logic              memwait;
  logic              redirect;
  logic              load_use;

  fwd_sel u_fwd_rs (
    .src          (rs_d),
    .use_src      (use_rs_d),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .alu_out_e    (alu_out_e),
    .result_m     (result_m),
    .result_w     (result_w),
    .enabled      (fwd_a_en),
    .value        (fwd_a_val)
  );

  fwd_sel u_fwd_rt (
    .src          (rt_d),
    .use_src      (use_rt_d),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .alu_out_e    (alu_out_e),
    .result_m     (result_m),
    .result_w     (result_w),
    .enabled      (fwd_b_en),
    .value        (fwd_b_val)
  );

  // Resolve the hazard cause for this cycle: memwait > redirect > load-use.
  // The entry cycle into MEMWAIT stalls combinationally. The completing cycle
  // (dmem_ready_m=1) releases the pipe. Any redirect or load-use seen during a
  // memory stall is simply re-evaluated once the stall drops.
  always_comb begin
    memwait  = ((state == HZ_MEMWAIT) || dmem_req_m) && !dmem_ready_m;
    redirect = branch_taken_e && !memwait;
    load_use = !memwait && !branch_taken_e && reg_write_e && mem_to_reg_e &&
               (write_reg_e != REG_ZERO) &&
               ((use_rs_d && (rs_d == write_reg_e)) ||
                (use_rt_d && (rt_d == write_reg_e)));
    stall_f               = 1'b0;
    stall_d               = 1'b0;
    stall_e               = 1'b0;
    stall_m               = 1'b0;
    flush_d               = 1'b0;
    flush_e               = 1'b0;
    forward_src_a_enabled = 1'b0;
    forward_src_a         = 32'd0;
    forward_src_b_enabled = 1'b0;
    forward_src_b         = 32'd0;
    if (!rst) begin
      forward_src_a_enabled = fwd_a_en;
      forward_src_a         = fwd_a_val;
      forward_src_b_enabled = fwd_b_en;
      forward_src_b         = fwd_b_val;
      if (memwait) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
      end else if (redirect) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end
    end
  end

  // Memory-wait FSM, timeout watchdog and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HZ_RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        HZ_RUN: begin
          wait_cnt <= '0;
          if (dmem_req_m && !dmem_ready_m) state <= HZ_MEMWAIT;
        end
        HZ_MEMWAIT: begin
          if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
          if (dmem_ready_m) state <= HZ_RUN;
        end
        default: state <= HZ_RUN;
      endcase
      if (stall_f && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
      if (redirect && (flush_count != '1)) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. The memory timeout is shortened to 4
// so that the watchdog can be reached.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs_d, rt_d;
  logic             use_rs_d, use_rt_d;
  logic [4:0]       write_reg_e, write_reg_m, write_reg_w;
  logic             reg_write_e, reg_write_m, reg_write_w;
  logic             mem_to_reg_e;
  logic [31:0]      alu_out_e, result_m, result_w;
  logic             branch_taken_e, dmem_req_m, dmem_ready_m;
  logic             stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
  logic             fwd_a_en, fwd_b_en;
  logic [31:0]      fwd_a, fwd_b;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  hz_state_t        state;

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .rs_d                  (rs_d),
    .rt_d                  (rt_d),
    .use_rs_d              (use_rs_d),
    .use_rt_d              (use_rt_d),
    .write_reg_e           (write_reg_e),
    .write_reg_m           (write_reg_m),
    .write_reg_w           (write_reg_w),
    .reg_write_e           (reg_write_e),
    .reg_write_m           (reg_write_m),
    .reg_write_w           (reg_write_w),
    .mem_to_reg_e          (mem_to_reg_e),
    .alu_out_e             (alu_out_e),
    .result_m              (result_m),
    .result_w              (result_w),
    .branch_taken_e        (branch_taken_e),
    .dmem_req_m            (dmem_req_m),
    .dmem_ready_m          (dmem_ready_m),
    .stall_f               (stall_f),
    .stall_d               (stall_d),
    .stall_e               (stall_e),
    .stall_m               (stall_m),
    .flush_d               (flush_d),
    .flush_e               (flush_e),
    .forward_src_a_enabled (fwd_a_en),
    .forward_src_a         (fwd_a),
    .forward_src_b_enabled (fwd_b_en),
    .forward_src_b         (fwd_b),
    .mem_timeout           (mem_timeout),
    .stall_cycles          (stall_cycles),
    .flush_count           (flush_count),
    .state                 (state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive inputs just after the falling edge so that checks land mid-cycle.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs_d = 5'd0; rt_d = 5'd0; use_rs_d = 1'b0; use_rt_d = 1'b0;
    write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    reg_write_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    mem_to_reg_e = 1'b0;
    alu_out_e = 32'd0; result_m = 32'd0; result_w = 32'd0;
    branch_taken_e = 1'b0; dmem_req_m = 1'b0; dmem_ready_m = 1'b0;
  endtask

  task automatic chk_stalls(input string tag, input logic [5:0] exp);
    chk({tag, ".sfdem_fde"}, {26'd0, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e}, {26'd0, exp});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    // Reset with a live forwarding match: everything must be forced low.
    rs_d = 5'd3; use_rs_d = 1'b1; write_reg_e = 5'd3; reg_write_e = 1'b1; alu_out_e = 32'h11;
    dmem_req_m = 1'b1;
    next_cycle(); next_cycle();
    #1;
    chk("rst.fwd_a_en", 32'(fwd_a_en), 32'd0);
    chk("rst.fwd_a", fwd_a, 32'd0);
    chk_stalls("rst", 6'b000000);
    chk("rst.state", 32'(state), 32'(HZ_RUN));
    chk("rst.stall_cycles", stall_cycles, 32'd0);
    chk("rst.flush_count", flush_count, 32'd0);
    chk("rst.timeout", 32'(mem_timeout), 32'd0);

    // $3 produced in E only: forward alu_out_e and do not stall.
    next_cycle(); rst = 1'b0; dmem_req_m = 1'b0; #1;
    chk("e_fwd.en", 32'(fwd_a_en), 32'd1);
    chk("e_fwd.val", fwd_a, 32'h11);
    chk_stalls("e_fwd", 6'b000000);

    // $3 produced in E, M and W: E wins. Then M once E drops. Then W.
    write_reg_m = 5'd3; reg_write_m = 1'b1; result_m = 32'h22;
    write_reg_w = 5'd3; reg_write_w = 1'b1; result_w = 32'h33;
    #1 chk("prio.e", fwd_a, 32'h11);
    reg_write_e = 1'b0;
    #1 chk("prio.m", fwd_a, 32'h22);
    reg_write_m = 1'b0;
    #1 chk("prio.w", fwd_a, 32'h33);
    // Reading $0 never forwards, even when producers target $0.
    reg_write_e = 1'b1; reg_write_m = 1'b1;
    rs_d = 5'd0; write_reg_e = 5'd0; write_reg_m = 5'd0; write_reg_w = 5'd0;
    #1 chk("zero.en", 32'(fwd_a_en), 32'd0);
    chk("zero.val", fwd_a, 32'd0);
    // A valid producer is ignored when the source is not actually read.
    rs_d = 5'd3; write_reg_m = 5'd3; use_rs_d = 1'b0;
    #1 chk("nouse.en", 32'(fwd_a_en), 32'd0);

    // lw $4 in E and the consumer reads rt=$4: insert one bubble.
    next_cycle(); idle_inputs();
    rt_d = 5'd4; use_rt_d = 1'b1; write_reg_e = 5'd4; reg_write_e = 1'b1; mem_to_reg_e = 1'b1;
    alu_out_e = 32'hdead; #1;
    chk_stalls("lu", 6'b110001);
    chk("lu.fwd_b_en", 32'(fwd_b_en), 32'd0);
    // Next cycle the load is in M: forward result_m and do not stall.
    next_cycle(); idle_inputs();
    rt_d = 5'd4; use_rt_d = 1'b1; write_reg_m = 5'd4; reg_write_m = 1'b1; result_m = 32'h44; #1;
    chk_stalls("lu_m", 6'b000000);
    chk("lu_m.fwd_b_en", 32'(fwd_b_en), 32'd1);
    chk("lu_m.fwd_b", fwd_b, 32'h44);
    chk("lu_m.stall_cycles", stall_cycles, 32'd1);

    // Taken branch together with a load-use: the redirect wins.
    next_cycle(); idle_inputs();
    rs_d = 5'd7; use_rs_d = 1'b1; write_reg_e = 5'd7; reg_write_e = 1'b1; mem_to_reg_e = 1'b1;
    branch_taken_e = 1'b1; #1;
    chk_stalls("br", 6'b000011);
    chk("br.flush_count_pre", flush_count, 32'd0);
    next_cycle(); idle_inputs(); #1;
    chk("br.flush_count", flush_count, 32'd1);
    chk("br.stall_cycles", stall_cycles, 32'd1);

    // Memory wait: ready is low for 3 cycles, then high.
    // A branch during the wait must not flush.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      dmem_req_m = 1'b1; dmem_ready_m = 1'b0; branch_taken_e = (i == 1); #1;
      chk_stalls($sformatf("mw%0d", i), 6'b111100);
      chk($sformatf("mw%0d.state", i), 32'(state), (i == 0) ? 32'(HZ_RUN) : 32'(HZ_MEMWAIT));
    end
    next_cycle(); branch_taken_e = 1'b0; dmem_ready_m = 1'b1; #1;
    chk_stalls("mw_done", 6'b000000);
    chk("mw_done.stall_cycles", stall_cycles, 32'd4);
    chk("mw_done.flush_count", flush_count, 32'd1);
    next_cycle(); idle_inputs(); #1;
    chk("mw_after.state", 32'(state), 32'(HZ_RUN));
    chk("mw_after.timeout", 32'(mem_timeout), 32'd0);

    // Ready is held low: the timeout fires after 4 cycles in MEMWAIT.
    for (int i = 0; i < 7; i++) begin
      if (i > 0) next_cycle();
      dmem_req_m = 1'b1; dmem_ready_m = 1'b0; #1;
      chk($sformatf("to%0d.timeout", i), 32'(mem_timeout), (i >= 5) ? 32'd1 : 32'd0);
      chk_stalls($sformatf("to%0d", i), 6'b111100);
    end

    // Reset during MEMWAIT: outputs drop at once, and state and counters clear.
    next_cycle(); rst = 1'b1; #1;
    chk_stalls("rst2", 6'b000000);
    next_cycle(); #1;
    chk("rst2.state", 32'(state), 32'(HZ_RUN));
    chk("rst2.timeout", 32'(mem_timeout), 32'd0);
    chk("rst2.stall_cycles", stall_cycles, 32'd0);
    chk("rst2.flush_count", flush_count, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
